// File: rtl/audio_i2s_transmitter_if.sv
// Sample-fetch handshake and I2S pins of the audio I2S transmitter.
// master = transmitter side, slave = FIFO/DAC side.
interface audio_i2s_transmitter_if;
    logic        o_busy;
    logic [15:0] i_sample;
    logic        o_bclk;
    logic        o_lrck;
    logic        o_sdata;

    modport master (
        output o_busy,
        input  i_sample,
        output o_bclk,
        output o_lrck,
        output o_sdata
    );

    modport slave (
        input  o_busy,
        output i_sample,
        input  o_bclk,
        input  o_lrck,
        input  o_sdata
    );
endinterface

// File: rtl/audio_i2s_transmitter.sv
// Audio I2S transmitter: fetches L/R 16-bit PCM pairs from the output FIFO via the
// busy/sample handshake and serialises them as a standard I2S stream (one-bit delay,
// MSB first, 32 BCLK slots per frame).
module audio_i2s_transmitter #(
    parameter int unsigned BCLK_DIV       = 4,
    parameter int unsigned SAMPLE_LATENCY = 3
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    audio_i2s_transmitter_if.master bus
);

    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned LAT_W = (SAMPLE_LATENCY > 1) ? $clog2(SAMPLE_LATENCY) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SAMPLE_LATENCY - 1);
    localparam bit TIMING_OK = (BCLK_DIV >= 2) && (SAMPLE_LATENCY >= 1) &&
                               (2 * (SAMPLE_LATENCY + 1) < 64 * BCLK_DIV);

    typedef enum logic [2:0] {
        IDLE,
        REQ_L,
        WAIT_L,
        REQ_R,
        WAIT_R,
        DONE
    } fetch_state_e;

    fetch_state_e     state;
    fetch_state_e     state_next;
    logic             busy;
    logic [DIV_W-1:0] div_cnt;
    logic             bclk;
    logic [4:0]       slot;
    logic             lrck;
    logic             sdata;
    logic [31:0]      word;
    logic [15:0]      staged_l;
    logic [15:0]      staged_r;
    logic [LAT_W-1:0] wait_cnt;
    logic             start_pending;

    logic             div_tc;
    logic             bclk_fall;
    logic [4:0]       slot_next;
    logic [4:0]       slot_bit;
    logic             frame_load;
    logic             wait_done;

    assign div_tc     = (div_cnt == DIV_LAST);
    assign bclk_fall  = div_tc & bclk;
    assign slot_next  = slot + 5'd1;
    // Slot k carries word bit (32-k) mod 32; slot 0 therefore picks word[0], the retained R[0].
    assign slot_bit   = 5'd0 - slot_next;
    assign frame_load = bclk_fall & (slot_next == 5'd1);
    assign wait_done  = (wait_cnt == LAT_LAST);

    assign bus.o_busy  = busy;
    assign bus.o_bclk  = bclk;
    assign bus.o_lrck  = lrck;
    assign bus.o_sdata = sdata;

    // BCLK generation: toggle every BCLK_DIV system clocks.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!i_enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Serialiser: on each BCLK falling edge advance the slot and drive LRCK/SDATA.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            slot  <= '0;
            lrck  <= 1'b0;
            sdata <= 1'b0;
            word  <= '0;
        end else if (!i_enable) begin
            slot  <= '0;
            lrck  <= 1'b0;
            sdata <= 1'b0;
            word  <= '0;
        end else if (bclk_fall) begin
            slot <= slot_next;
            lrck <= slot_next[4];
            if (frame_load) begin
                word  <= {staged_l, staged_r};
                sdata <= staged_l[15];
            end else begin
                sdata <= word[slot_bit];
            end
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else if (!i_enable) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch FSM next state and request strobe; a frame load always restarts the fetch.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            IDLE:    if (start_pending) state_next = REQ_L;
            REQ_L: begin
                busy       = 1'b0;
                state_next = WAIT_L;
            end
            WAIT_L:  if (wait_done) state_next = REQ_R;
            REQ_R: begin
                busy       = 1'b0;
                state_next = WAIT_R;
            end
            WAIT_R:  if (wait_done) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (frame_load) state_next = REQ_L;
    end

    // Fetch datapath: latency counter, staged sample capture, start-up fetch flag.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wait_cnt      <= '0;
            staged_l      <= '0;
            staged_r      <= '0;
            start_pending <= 1'b1;
        end else if (!i_enable) begin
            wait_cnt      <= '0;
            staged_l      <= '0;
            staged_r      <= '0;
            start_pending <= 1'b1;
        end else begin
            if (((state == WAIT_L) || (state == WAIT_R)) && !wait_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if ((state == WAIT_L) && wait_done) staged_l <= bus.i_sample;
            if ((state == WAIT_R) && wait_done) staged_r <= bus.i_sample;
            if (state == IDLE) start_pending <= 1'b0;
        end
    end

    // Both fetches must fit inside one frame.
    always_ff @(posedge i_clock) begin
        assert (TIMING_OK)
            else $error("audio_i2s_transmitter: fetch latency does not fit in one frame");
    end

endmodule
